// File: rtl/main_memory.sv
// Word-addressed single-port memory that sits behind the CPU bus: programmable wait states,
// a one-cycle completion pulse, a freeze after end-of-program, a preload port and a registered dump port.
module main_memory #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  mem_enable_i,
   input  logic                  mem_rd_en_i,
   input  logic                  mem_wr_en_i,
   input  logic [ADDR_WIDTH-1:0] mem_addr_i,
   input  logic [DATA_WIDTH-1:0] mem_value_i,
   input  logic                  end_program_i,
   input  logic                  load_en_i,
   input  logic [ADDR_WIDTH-1:0] load_addr_i,
   input  logic [DATA_WIDTH-1:0] load_data_i,
   input  logic [ADDR_WIDTH-1:0] dump_addr_i,
   output logic [DATA_WIDTH-1:0] mem_value_o,
   output logic                  mem_valid_o,
   output logic                  mem_busy_o,
   output logic                  halted_o,
   output logic                  proto_err_o,
   output logic [DATA_WIDTH-1:0] dump_data_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP,
      S_HALT
   } state_t;

   localparam int         DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic                  op_wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  valid_q;
   logic                  busy_q;
   logic                  halted_q;
   logic                  perr_q;
   logic                  halt_pend_q;
   logic [DATA_WIDTH-1:0] dump_q;

   logic                  req_ok;
   logic                  req_bad;
   logic                  accept_slot;
   logic                  load_ok;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // RESP's exit edge doubles as an acceptance edge, giving one access per WAIT_STATES+2 cycles.
   always_comb begin
      req_ok      = mem_enable_i & (mem_rd_en_i ^ mem_wr_en_i);
      req_bad     = mem_enable_i & mem_rd_en_i & mem_wr_en_i;
      accept_slot = !end_program_i &&
                    ((state_q == S_IDLE) || ((state_q == S_RESP) && !halt_pend_q));
      load_ok     = load_en_i && ((state_q == S_IDLE) || (state_q == S_HALT));
      mem_we      = 1'b0;
      mem_waddr   = addr_q;
      mem_wdata   = wdata_q;
      if ((state_q == S_WAIT) && (cnt_q == '0) && op_wr_q) begin
         mem_we = 1'b1;
      end else if (load_ok) begin
         mem_we    = 1'b1;
         mem_waddr = load_addr_i;
         mem_wdata = load_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we && rst_i) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_wr_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
         perr_q      <= 1'b0;
         halt_pend_q <= 1'b0;
         dump_q      <= '0;
      end else begin
         dump_q <= mem_q[dump_addr_i];
         case (state_q)
            S_IDLE, S_RESP: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               if ((state_q == S_RESP) && load_en_i) begin
                  perr_q <= 1'b1;
               end
               if (!accept_slot) begin
                  state_q     <= S_HALT;
                  halted_q    <= 1'b1;
                  halt_pend_q <= 1'b0;
               end else if (req_bad) begin
                  perr_q <= 1'b1;
               end else if (req_ok) begin
                  state_q <= S_WAIT;
                  busy_q  <= 1'b1;
                  op_wr_q <= mem_wr_en_i;
                  addr_q  <= mem_addr_i;
                  wdata_q <= mem_value_i;
                  cnt_q   <= CNT_INIT;
                  if (load_en_i) begin
                     perr_q <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (end_program_i) begin
                  halt_pend_q <= 1'b1;
               end
               if (load_en_i) begin
                  perr_q <= 1'b1;
               end
               if (cnt_q == '0) begin
                  if (!op_wr_q) begin
                     rdata_q <= mem_q[addr_q];
                  end
                  valid_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_HALT: begin
               halted_q <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_value_o = rdata_q;
   assign mem_valid_o = valid_q;
   assign mem_busy_o  = busy_q;
   assign halted_o    = halted_q;
   assign proto_err_o = perr_q;
   assign dump_data_o = dump_q;

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: three instances (0, 1 and 3 wait states) share one stimulus bus;
// each scenario checks the instance whose timing it targets.
module tb_main_memory;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0, rd = 1'b0, wr = 1'b0, endp = 1'b0, ld = 1'b0;
   logic [7:0]  addr = '0, ld_addr = '0, dump_addr = '0;
   logic [15:0] wdata = '0, ld_data = '0;

   logic [15:0] w0_value, w1_value, w3_value, w0_dump, w1_dump, w3_dump;
   logic        w0_valid, w1_valid, w3_valid, w0_busy, w1_busy, w3_busy;
   logic        w0_halt, w1_halt, w3_halt, w0_perr, w1_perr, w3_perr;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   main_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(0)) u_w0 (
      .clk_i(clk), .rst_i(rst), .mem_enable_i(en), .mem_rd_en_i(rd), .mem_wr_en_i(wr),
      .mem_addr_i(addr), .mem_value_i(wdata), .end_program_i(endp), .load_en_i(ld),
      .load_addr_i(ld_addr), .load_data_i(ld_data), .dump_addr_i(dump_addr),
      .mem_value_o(w0_value), .mem_valid_o(w0_valid), .mem_busy_o(w0_busy),
      .halted_o(w0_halt), .proto_err_o(w0_perr), .dump_data_o(w0_dump));

   main_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(1)) u_w1 (
      .clk_i(clk), .rst_i(rst), .mem_enable_i(en), .mem_rd_en_i(rd), .mem_wr_en_i(wr),
      .mem_addr_i(addr), .mem_value_i(wdata), .end_program_i(endp), .load_en_i(ld),
      .load_addr_i(ld_addr), .load_data_i(ld_data), .dump_addr_i(dump_addr),
      .mem_value_o(w1_value), .mem_valid_o(w1_valid), .mem_busy_o(w1_busy),
      .halted_o(w1_halt), .proto_err_o(w1_perr), .dump_data_o(w1_dump));

   main_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(3)) u_w3 (
      .clk_i(clk), .rst_i(rst), .mem_enable_i(en), .mem_rd_en_i(rd), .mem_wr_en_i(wr),
      .mem_addr_i(addr), .mem_value_i(wdata), .end_program_i(endp), .load_en_i(ld),
      .load_addr_i(ld_addr), .load_data_i(ld_data), .dump_addr_i(dump_addr),
      .mem_value_o(w3_value), .mem_valid_o(w3_valid), .mem_busy_o(w3_busy),
      .halted_o(w3_halt), .proto_err_o(w3_perr), .dump_data_o(w3_dump));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      en = 1'b0; rd = 1'b0; wr = 1'b0; endp = 1'b0; ld = 1'b0;
   endtask

   task automatic do_reset();
      idle_bus();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [15:0] d);
      ld = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld = 1'b0;
   endtask

   task automatic test_reset();
      idle_bus();
      #2 rst = 1'b0;
      #1;
      if ({w1_value, w1_valid, w1_busy, w1_halt, w1_perr, w1_dump} !== 36'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%0h exp=0",
                  {w1_value, w1_valid, w1_busy, w1_halt, w1_perr, w1_dump});
      end
      checks++;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_read_latency();
      do_reset();
      preload(8'h10, 16'hBEEF);
      en = 1'b1; rd = 1'b1; addr = 8'h10;
      tick();  // E0
      idle_bus();
      if (w1_busy !== 1'b1 || w1_valid !== 1'b0) begin
         failures++; $display("FAIL rd_E0 busy=%0b valid=%0b exp busy=1 valid=0", w1_busy, w1_valid);
      end
      checks++;
      tick();  // E1
      if (w1_busy !== 1'b1 || w1_valid !== 1'b0) begin
         failures++; $display("FAIL rd_E1 busy=%0b valid=%0b exp busy=1 valid=0", w1_busy, w1_valid);
      end
      checks++;
      tick();  // E2 completion
      if (w1_busy !== 1'b0 || w1_valid !== 1'b1 || w1_value !== 16'hBEEF) begin
         failures++;
         $display("FAIL rd_E2 busy=%0b valid=%0b value=%0h exp busy=0 valid=1 value=beef",
                  w1_busy, w1_valid, w1_value);
      end
      checks++;
      tick();
      if (w1_valid !== 1'b0 || w1_value !== 16'hBEEF) begin
         failures++; $display("FAIL rd_hold valid=%0b value=%0h exp valid=0 value=beef", w1_valid, w1_value);
      end
      checks++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      en = 1'b1; wr = 1'b1; addr = 8'h05; wdata = 16'h1234;
      tick();  // E0 write accepted
      wr = 1'b0; rd = 1'b1;
      tick();  // E1 write completes
      if (w0_valid !== 1'b1) begin
         failures++; $display("FAIL b2b_wr_valid got=%0b exp=1", w0_valid);
      end
      checks++;
      tick();  // E2 read accepted
      if (w0_valid !== 1'b0 || w0_busy !== 1'b1) begin
         failures++; $display("FAIL b2b_rd_accept valid=%0b busy=%0b exp valid=0 busy=1", w0_valid, w0_busy);
      end
      checks++;
      idle_bus();
      dump_addr = 8'h05;
      tick();  // E3 read completes
      if (w0_valid !== 1'b1 || w0_value !== 16'h1234) begin
         failures++; $display("FAIL b2b_rd_data valid=%0b value=%0h exp valid=1 value=1234", w0_valid, w0_value);
      end
      checks++;
      tick();
      if (w0_dump !== 16'h1234 || w0_valid !== 1'b0) begin
         failures++; $display("FAIL b2b_dump dump=%0h valid=%0b exp dump=1234 valid=0", w0_dump, w0_valid);
      end
      checks++;
   endtask

   task automatic test_proto_err();
      do_reset();
      preload(8'h40, 16'h0A0A);
      en = 1'b1; rd = 1'b1; addr = 8'h41;
      tick();  // accepted, now in WAIT
      idle_bus();
      ld = 1'b1; ld_addr = 8'h40; ld_data = 16'hFFFF;
      tick();
      ld = 1'b0;
      dump_addr = 8'h40;
      if (w1_perr !== 1'b1) begin
         failures++; $display("FAIL perr_load_in_wait got=%0b exp=1", w1_perr);
      end
      checks++;
      tick();
      tick();
      if (w1_dump !== 16'h0A0A) begin
         failures++; $display("FAIL perr_load_ignored got=%0h exp=a0a", w1_dump);
      end
      checks++;
      do_reset();
      en = 1'b1; rd = 1'b1; wr = 1'b1; addr = 8'h40;
      tick();
      idle_bus();
      if (w1_perr !== 1'b1 || w1_busy !== 1'b0) begin
         failures++; $display("FAIL perr_rdwr perr=%0b busy=%0b exp perr=1 busy=0", w1_perr, w1_busy);
      end
      checks++;
      tick();
      tick();
      tick();
      if (w1_perr !== 1'b1 || w1_valid !== 1'b0 || w1_busy !== 1'b0) begin
         failures++;
         $display("FAIL perr_sticky perr=%0b valid=%0b busy=%0b exp perr=1 valid=0 busy=0",
                  w1_perr, w1_valid, w1_busy);
      end
      checks++;
   endtask

   task automatic test_end_program();
      do_reset();
      en = 1'b1; wr = 1'b1; addr = 8'h20; wdata = 16'hAAAA;
      tick();  // E0
      idle_bus();
      endp = 1'b1;
      tick();  // E1 in WAIT, halt pending
      endp = 1'b0;
      tick();  // E2 completion
      if (w1_valid !== 1'b1 || w1_halt !== 1'b0) begin
         failures++; $display("FAIL end_complete valid=%0b halted=%0b exp valid=1 halted=0", w1_valid, w1_halt);
      end
      checks++;
      tick();
      if (w1_halt !== 1'b1 || w1_valid !== 1'b0) begin
         failures++; $display("FAIL end_halted halted=%0b valid=%0b exp halted=1 valid=0", w1_halt, w1_valid);
      end
      checks++;
      en = 1'b1; rd = 1'b1; addr = 8'h20;
      tick();
      tick();
      tick();
      if (w1_valid !== 1'b0 || w1_busy !== 1'b0 || w1_perr !== 1'b0) begin
         failures++;
         $display("FAIL halt_ignores_rd valid=%0b busy=%0b perr=%0b exp 0 0 0", w1_valid, w1_busy, w1_perr);
      end
      checks++;
      idle_bus();
      dump_addr = 8'h20;
      preload(8'h21, 16'h7777);
      if (w1_dump !== 16'hAAAA) begin
         failures++; $display("FAIL halt_write_landed got=%0h exp=aaaa", w1_dump);
      end
      checks++;
      dump_addr = 8'h21;
      tick();
      if (w1_dump !== 16'h7777) begin
         failures++; $display("FAIL halt_preload got=%0h exp=7777", w1_dump);
      end
      checks++;
   endtask

   task automatic test_reset_mid_write();
      do_reset();
      preload(8'h30, 16'h0001);
      en = 1'b1; wr = 1'b1; addr = 8'h30; wdata = 16'h5555;
      tick();  // E0
      idle_bus();
      tick();  // still in WAIT for three wait states
      if (w3_busy !== 1'b1) begin
         failures++; $display("FAIL midwr_busy got=%0b exp=1", w3_busy);
      end
      checks++;
      rst = 1'b0;
      #1;
      if ({w3_value, w3_valid, w3_busy, w3_halt, w3_perr, w3_dump} !== 36'd0) begin
         failures++;
         $display("FAIL midwr_async_clear got=%0h exp=0",
                  {w3_value, w3_valid, w3_busy, w3_halt, w3_perr, w3_dump});
      end
      checks++;
      tick();
      tick();
      tick();
      rst = 1'b1;
      dump_addr = 8'h30;
      tick();
      if (w3_dump !== 16'h0001 || w3_valid !== 1'b0) begin
         failures++; $display("FAIL midwr_discard dump=%0h valid=%0b exp dump=1 valid=0", w3_dump, w3_valid);
      end
      checks++;
   endtask

   task automatic test_end_vs_request();
      do_reset();
      en = 1'b1; rd = 1'b1; addr = 8'h10; endp = 1'b1;
      tick();
      idle_bus();
      if (w1_halt !== 1'b1 || w1_busy !== 1'b0) begin
         failures++; $display("FAIL endreq_halt halted=%0b busy=%0b exp halted=1 busy=0", w1_halt, w1_busy);
      end
      checks++;
      tick();
      tick();
      if (w1_valid !== 1'b0 || w1_busy !== 1'b0) begin
         failures++; $display("FAIL endreq_dropped valid=%0b busy=%0b exp 0 0", w1_valid, w1_busy);
      end
      checks++;
   endtask

   initial begin
      test_reset();
      test_read_latency();
      test_back_to_back();
      test_proto_err();
      test_end_program();
      test_reset_mid_write();
      test_end_vs_request();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
